// File: rtl/operand_exec_stage.sv
// operand_exec_stage: register file read, immediate extend, ALU execute and EX/MEM registers
module operand_exec_stage #(
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       Aselect,
    input  logic [31:0]       Bselect,
    input  logic [15:0]       imm16,
    input  logic              Imm,
    input  logic [2:0]        S,
    input  logic              Cin,
    input  logic              LW,
    input  logic              SW,
    input  logic [31:0]       Dselect,
    input  logic [31:0]       wb_dsel,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] dbus_ex,
    output logic [DATA_W-1:0] sdata_ex,
    output logic [31:0]       dsel_ex,
    output logic              lw_ex,
    output logic              sw_ex,
    output logic              cout_ex
);
    logic [DATA_W-1:0] rf  [32];
    logic [DATA_W-1:0] eff [32];
    logic [DATA_W-1:0] ra, rb, abus, bbus, imm_ext, opb, bx, lg, res;
    logic [DATA_W:0]   sum;
    logic              arith;

    for (genvar i = 0; i < 32; i++) begin : g_eff
        assign eff[i] = (ZERO_REG != 0 && i == 0) ? '0 : wb_dsel[i] ? wb_data : rf[i];
    end

    // wired-OR read of every selected register, with writeback bypass folded in
    always_comb begin
        ra = '0;
        rb = '0;
        for (int k = 0; k < 32; k++) begin
            ra = ra | (Aselect[k] ? eff[k] : '0);
            rb = rb | (Bselect[k] ? eff[k] : '0);
        end
    end

    // register file writes; every selected register takes the writeback value
    always_ff @(posedge clk) begin
        for (int k = 0; k < 32; k++)
            if (!rst_n) rf[k] <= '0;
            else if (wb_dsel[k] && !(ZERO_REG != 0 && k == 0)) rf[k] <= wb_data;
    end

    // ID/EX operand latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abus    <= '0;
            bbus    <= '0;
            imm_ext <= '0;
        end else begin
            abus    <= ra;
            bbus    <= rb;
            imm_ext <= {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    // ALU: S[2:1] picks the function, S[0] inverts logic results or operand B for the adder
    always_comb begin
        opb   = Imm ? imm_ext : bbus;
        bx    = opb ^ {DATA_W{S[0]}};
        sum   = {1'b0, abus} + {1'b0, bx} + {{DATA_W{1'b0}}, Cin};
        arith = S[2:1] == 2'b01;
        lg    = S[2:1] == 2'b00 ? abus ^ opb : S[2:1] == 2'b10 ? abus | opb : abus & opb;
        res   = arith ? sum[DATA_W-1:0] : lg ^ {DATA_W{S[0]}};
    end

    // EX/MEM registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dbus_ex  <= '0;
            sdata_ex <= '0;
            dsel_ex  <= '0;
            lw_ex    <= 1'b0;
            sw_ex    <= 1'b0;
            cout_ex  <= 1'b0;
        end else begin
            dbus_ex  <= res;
            sdata_ex <= bbus;
            dsel_ex  <= Dselect;
            lw_ex    <= LW;
            sw_ex    <= SW;
            cout_ex  <= arith & sum[DATA_W];
        end
    end
endmodule

// File: tb/tb_operand_exec_stage.sv
// tb_operand_exec_stage: directed and random checks against a register-array reference model
module tb_operand_exec_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Aselect = '0, Bselect = '0, Dselect = '0, wb_dsel = '0, wb_data = '0;
    logic [15:0] imm16 = '0;
    logic        Imm = 1'b0, Cin = 1'b0, LW = 1'b0, SW = 1'b0;
    logic [2:0]  S = '0;
    logic [31:0] dbus_ex, sdata_ex, dsel_ex;
    logic        lw_ex, sw_ex, cout_ex;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] a, b, imm;
        logic        isel;
        logic [2:0]  s;
        logic        cin, lw, sw;
        logic [31:0] d;
    } op_t;

    op_t         pend = '0;
    logic [31:0] mreg [32];

    operand_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .Aselect(Aselect), .Bselect(Bselect), .imm16(imm16),
        .Imm(Imm), .S(S), .Cin(Cin), .LW(LW), .SW(SW), .Dselect(Dselect),
        .wb_dsel(wb_dsel), .wb_data(wb_data), .dbus_ex(dbus_ex), .sdata_ex(sdata_ex),
        .dsel_ex(dsel_ex), .lw_ex(lw_ex), .sw_ex(sw_ex), .cout_ex(cout_ex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] sel, input logic [31:0] ws, input logic [31:0] wd);
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++)
            if (sel[i]) v |= ws[i] ? wd : mreg[i];
        return v;
    endfunction

    function automatic logic [32:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s, input logic cin);
        case (s)
            3'd0: return {1'b0, a ^ b};
            3'd1: return {1'b0, ~(a ^ b)};
            3'd2: return {1'b0, a} + {1'b0, b} + 33'(cin);
            3'd3: return {1'b0, a} + {1'b0, ~b} + 33'(cin);
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, ~(a | b)};
            3'd6: return {1'b0, a & b};
            default: return {1'b0, ~(a & b)};
        endcase
    endfunction

    task automatic step(input logic [31:0] asel, input logic [31:0] bsel, input logic [15:0] i16,
                        input logic isel, input logic [2:0] s, input logic cin, input logic lw,
                        input logic sw, input logic [31:0] d, input logic [31:0] wsel,
                        input logic [31:0] wdat, input logic rn);
        logic [32:0] r;
        op_t nx;
        Aselect = asel; Bselect = bsel; imm16 = i16; wb_dsel = wsel; wb_data = wdat; rst_n = rn;
        Imm = pend.isel; S = pend.s; Cin = pend.cin; LW = pend.lw; SW = pend.sw; Dselect = pend.d;
        r = alu(pend.a, pend.isel ? pend.imm : pend.b, pend.s, pend.cin);
        nx = '{a: rd(asel, wsel, wdat), b: rd(bsel, wsel, wdat), imm: 32'($signed(i16)),
               isel: isel, s: s, cin: cin, lw: lw, sw: sw, d: d};
        @(posedge clk);
        for (int i = 0; i < 32; i++)
            if (!rn) mreg[i] = '0;
            else if (wsel[i] && i != 0) mreg[i] = wdat;
        #1;
        chk("dbus_ex", dbus_ex, rn ? r[31:0] : '0);
        chk("cout_ex", {31'b0, cout_ex}, rn ? {31'b0, r[32]} : '0);
        chk("sdata_ex", sdata_ex, rn ? pend.b : '0);
        chk("dsel_ex", dsel_ex, rn ? pend.d : '0);
        chk("lw_ex", {31'b0, lw_ex}, {31'b0, rn & pend.lw});
        chk("sw_ex", {31'b0, sw_ex}, {31'b0, rn & pend.sw});
        pend = rn ? nx : '0;
    endtask

    task automatic wr(input int idx, input logic [31:0] v);
        step('0, '0, '0, 0, '0, 0, 0, 0, '0, 32'(1) << idx, v, 1'b1);
    endtask

    task automatic iss(input int a, input int b, input logic [15:0] i16, input logic isel,
                       input logic [2:0] s, input logic cin, input logic lw, input logic sw, input int d);
        step(32'(1) << a, 32'(1) << b, i16, isel, s, cin, lw, sw, 32'(1) << d, '0, '0, 1'b1);
    endtask

    task automatic idle();
        step('0, '0, '0, 0, '0, 0, 0, 0, '0, '0, '0, 1'b1);
    endtask

    function automatic logic [31:0] rsel();
        int m = $urandom_range(0, 3);
        return m == 0 ? '0 : m == 3 ? (32'(1) << $urandom_range(0, 31)) | (32'(1) << $urandom_range(0, 31))
                                    : 32'(1) << $urandom_range(0, 31);
    endfunction

    initial begin
        step('0, '0, '0, 0, '0, 0, 0, 0, '0, 32'(1) << 5, 32'hFFFF_FFFF, 1'b0);
        step('0, '0, '0, 0, '0, 0, 0, 0, '0, 32'(1) << 5, 32'hFFFF_FFFF, 1'b0);
        chk("reset_dbus", dbus_ex, '0);
        iss(5, 0, '0, 0, 3'd4, 0, 0, 0, 0);
        idle();
        chk("reset_r5", dbus_ex, '0);

        wr(1, 32'd5); wr(2, 32'd3);
        iss(1, 2, '0, 0, 3'd2, 0, 0, 0, 3);
        idle();
        chk("add_dbus", dbus_ex, 32'd8);
        chk("add_cout", {31'b0, cout_ex}, '0);
        chk("add_dsel", dsel_ex, 32'h8);

        wr(1, 32'd3); wr(2, 32'd5);
        iss(1, 2, '0, 0, 3'd3, 1, 0, 0, 3);
        iss(2, 1, '0, 0, 3'd3, 1, 0, 0, 3);
        chk("sub_wrap", dbus_ex, 32'hFFFF_FFFE);
        chk("sub_wrap_cout", {31'b0, cout_ex}, '0);
        idle();
        chk("sub_swap", dbus_ex, 32'd2);
        chk("sub_swap_cout", {31'b0, cout_ex}, 32'd1);

        wr(4, 32'h1000);
        iss(4, 0, 16'hFFFC, 1, 3'd2, 0, 1, 0, 6);
        idle();
        chk("lw_addr", dbus_ex, 32'h0000_0FFC);
        chk("lw_flag", {31'b0, lw_ex}, 32'd1);
        chk("lw_sw", {31'b0, sw_ex}, '0);

        wr(9, 32'hCAFE_0001);
        iss(4, 9, 16'h0010, 1, 3'd2, 0, 0, 1, 9);
        idle();
        chk("sw_addr", dbus_ex, 32'h1010);
        chk("sw_data", sdata_ex, 32'hCAFE_0001);
        chk("sw_dsel", dsel_ex, 32'(1) << 9);

        step(32'(1) << 7, 32'(1), '0, 0, 3'd4, 0, 0, 0, '0, 32'(1) << 7, 32'h1234_5678, 1'b1);
        idle();
        chk("bypass", dbus_ex, 32'h1234_5678);
        wr(0, 32'hDEAD_BEEF);
        iss(0, 0, '0, 0, 3'd4, 0, 0, 0, 0);
        idle();
        chk("r0_zero", dbus_ex, '0);

        wr(1, 32'hF0F0_F0F0); wr(2, 32'hFF00_FF00);
        iss(1, 2, '0, 0, 3'd0, 0, 0, 0, 1);
        iss(1, 2, '0, 0, 3'd6, 0, 0, 0, 1);
        chk("xor", dbus_ex, 32'h0FF0_0FF0);
        iss(1, 2, '0, 0, 3'd4, 0, 0, 0, 1);
        chk("and", dbus_ex, 32'hF000_F000);
        iss(1, 2, '0, 0, 3'd5, 0, 0, 0, 1);
        chk("or", dbus_ex, 32'hFFF0_FFF0);
        idle();
        chk("nor", dbus_ex, 32'h000F_000F);

        for (int n = 0; n < 400; n++)
            step(rsel(), rsel(), 16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), rsel(), rsel(), $urandom, $urandom_range(0, 24) != 0);
        idle(); idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
